// File: rtl/interrupt_ctrl_pkg.sv
// Shared constants, types and helpers for the vectored interrupt controller.
// Vector table layout, nesting depth and status-port bit positions live here.
package interrupt_ctrl_pkg;

  localparam int NUM_IRQ = 4;
  localparam int ID_W    = 2;
  localparam int PC_W    = 10;
  localparam int NEST    = 4;
  localparam int DEPTH_W = 3;

  localparam logic [PC_W-1:0] VEC_BASE   = 10'h3C0;
  localparam logic [PC_W-1:0] VEC_STRIDE = 10'd4;

  localparam int CTRL_GIE = 7;

  localparam int ST_GIE   = 7;
  localparam int ST_BUSY  = 6;
  localparam int ST_ID_HI = 5;
  localparam int ST_ID_LO = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_TAKE = 1'b1
  } state_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            z;
    logic [ID_W-1:0] id;
  } stack_entry_t;

  // Wraps modulo 2^PC_W by construction of the result width.
  function automatic logic [PC_W-1:0] vector_addr(input logic [ID_W-1:0] id);
    return VEC_BASE + PC_W'(id) * VEC_STRIDE;
  endfunction

  // Lowest set index wins; returns 0 when nothing is requested.
  function automatic logic [ID_W-1:0] prio_sel(input logic [NUM_IRQ-1:0] req);
    logic [ID_W-1:0] sel;
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) sel = ID_W'(i);
    end
    return sel;
  endfunction

endpackage

// File: rtl/interrupt_ctrl_irq_stack.sv
// Nesting stack for the interrupt controller: LIFO of {return pc, Z flag, source id}.
// The top entry is read combinationally so RETI can restore in the same cycle.
module interrupt_ctrl_irq_stack
  import interrupt_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic               pop_i,
  input  stack_entry_t       push_data_i,
  output stack_entry_t       top_o,
  output logic [DEPTH_W-1:0] depth_o
);

  localparam int IDX_W = (NEST > 1) ? $clog2(NEST) : 1;

  stack_entry_t       entry_arr [NEST];
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [IDX_W-1:0]   top_idx;
  logic               full, empty, do_push, do_pop;

  assign full    = (depth_q == DEPTH_W'(NEST));
  assign empty   = (depth_q == '0);
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty && !push_i;

  always_comb begin
    depth_d = depth_q;
    if (do_push) begin
      depth_d = depth_q + DEPTH_W'(1);
    end else if (do_pop) begin
      depth_d = depth_q - DEPTH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NEST; gi++) begin : g_entry
      stack_entry_t entry_q;

      always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
          entry_q <= '0;
        end else if (do_push && (depth_q == DEPTH_W'(gi))) begin
          entry_q <= push_data_i;
        end
      end

      assign entry_arr[gi] = entry_q;
    end
  endgenerate

  // When empty the index wraps; the output is forced to zero in that case.
  assign top_idx = IDX_W'(depth_q - DEPTH_W'(1));
  assign top_o   = empty ? '0 : entry_arr[top_idx];
  assign depth_o = depth_q;

endmodule

// File: rtl/interrupt_ctrl.sv
// Vectored interrupt controller: rising-edge IRQ latching, fixed-priority preemptive
// arbitration, PC/Z override toward the CPU datapath, and nesting via a return stack.
module interrupt_ctrl
  import interrupt_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [PC_W-1:0]    pc_next,
  input  logic               z_in,
  input  logic               reti,
  input  logic               we_mask,
  input  logic [7:0]         ctrl_in,
  output logic               s_int,
  output logic [PC_W-1:0]    pc_int,
  output logic               s_zrest,
  output logic               z_rest,
  output logic [NUM_IRQ-1:0] ack,
  output logic [7:0]         status
);

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic               gie_q, gie_d;
  logic [NUM_IRQ-1:0] en_q, en_d;
  state_e             state_q, state_d;
  logic [ID_W-1:0]    sel_q, sel_d;

  logic [NUM_IRQ-1:0] eligible;
  logic [ID_W-1:0]    sel;
  logic [ID_W-1:0]    cur_id;
  logic               busy, take_ok, do_reti;
  logic               push, pop;
  stack_entry_t       push_data, top;
  logic [DEPTH_W-1:0] depth;
  logic               unused_ctrl;

  assign unused_ctrl = ^ctrl_in[6:4];

  interrupt_ctrl_irq_stack u_stack (
    .clk         (clk),
    .rst_ni      (reset),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (push_data),
    .top_o       (top),
    .depth_o     (depth)
  );

  assign eligible = pending_q & en_q & {NUM_IRQ{gie_q}};
  assign sel      = prio_sel(eligible);
  assign busy     = (depth != '0);
  assign cur_id   = busy ? top.id : '0;
  assign do_reti  = reti && busy;

  // Nesting is only allowed for a strictly higher-priority source with room on the stack.
  assign take_ok  = (|eligible) && (!busy || (sel < cur_id)) && (depth < DEPTH_W'(NEST));

  assign push_data.pc = pc_next;
  assign push_data.z  = z_in;
  assign push_data.id = sel_q;

  always_comb begin
    state_d = state_q;
    s_int   = 1'b0;
    pc_int  = '0;
    s_zrest = 1'b0;
    z_rest  = 1'b0;
    ack     = '0;
    push    = 1'b0;
    pop     = 1'b0;
    // RETI beats a pending TAKE; the take is re-arbitrated against the restored cur_id.
    if (do_reti) begin
      s_int   = 1'b1;
      pc_int  = top.pc;
      s_zrest = 1'b1;
      z_rest  = top.z;
      pop     = 1'b1;
      state_d = S_IDLE;
    end else if (state_q == S_TAKE) begin
      s_int      = 1'b1;
      pc_int     = vector_addr(sel_q);
      ack[sel_q] = 1'b1;
      push       = 1'b1;
      state_d    = S_IDLE;
    end else if (take_ok && !reti) begin
      state_d = S_TAKE;
    end
  end

  always_comb begin
    pending_d = (pending_q & ~ack) | (irq & ~irq_q);
    sel_d     = (state_q == S_IDLE) ? sel : sel_q;
    gie_d     = gie_q;
    en_d      = en_q;
    if (we_mask) begin
      gie_d = ctrl_in[CTRL_GIE];
      en_d  = ctrl_in[NUM_IRQ-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q     <= '0;
      pending_q <= '0;
      gie_q     <= 1'b0;
      en_q      <= '0;
      state_q   <= S_IDLE;
      sel_q     <= '0;
    end else begin
      irq_q     <= irq;
      pending_q <= pending_d;
      gie_q     <= gie_d;
      en_q      <= en_d;
      state_q   <= state_d;
      sel_q     <= sel_d;
    end
  end

  always_comb begin
    status                    = '0;
    status[ST_GIE]            = gie_q;
    status[ST_BUSY]           = busy;
    status[ST_ID_HI:ST_ID_LO] = cur_id;
    status[NUM_IRQ-1:0]       = pending_q;
  end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Self-checking bench for interrupt_ctrl: expected PC/Z overrides are queued as stimulus
// is applied and compared whenever the controller drives s_int.
module tb_interrupt_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] irq;
  logic [9:0] pc_next;
  logic       z_in;
  logic       reti;
  logic       we_mask;
  logic [7:0] ctrl_in;
  logic       s_int;
  logic [9:0] pc_int;
  logic       s_zrest;
  logic       z_rest;
  logic [3:0] ack;
  logic [7:0] status;

  typedef struct packed {
    logic [9:0] pc;
    logic       zr;
    logic       z;
    logic [3:0] ack;
  } exp_t;

  exp_t sb_q[$];
  int   checks_cnt = 0;
  int   errors_cnt = 0;

  interrupt_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .irq     (irq),
    .pc_next (pc_next),
    .z_in    (z_in),
    .reti    (reti),
    .we_mask (we_mask),
    .ctrl_in (ctrl_in),
    .s_int   (s_int),
    .pc_int  (pc_int),
    .s_zrest (s_zrest),
    .z_rest  (z_rest),
    .ack     (ack),
    .status  (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic sb_push(input logic [9:0] pc, input logic zr, input logic z, input logic [3:0] a);
    exp_t e;
    e.pc  = pc;
    e.zr  = zr;
    e.z   = z;
    e.ack = a;
    sb_q.push_back(e);
  endtask

  task automatic write_ctrl(input logic [7:0] v);
    we_mask = 1'b1;
    ctrl_in = v;
    tick();
    we_mask = 1'b0;
  endtask

  task automatic pulse_irq(input int id);
    irq     = '0;
    irq[id] = 1'b1;
    tick();
    irq = '0;
  endtask

  // Every PC override must match the oldest queued expectation.
  always @(negedge clk) begin
    if (s_int) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected_sint", 32'(s_int), 32'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("override pc_int=%0h s_zrest=%0b z_rest=%0b ack=%b", pc_int, s_zrest, z_rest, ack);
        check_eq("sb_pc_int", 32'(pc_int), 32'(e.pc));
        check_eq("sb_s_zrest", 32'(s_zrest), 32'(e.zr));
        check_eq("sb_z_rest", 32'(z_rest), 32'(e.z));
        check_eq("sb_ack", 32'(ack), 32'(e.ack));
      end
    end else if ((ack != 4'b0000) || s_zrest) begin
      check_eq("sb_spurious_ack_zrest", 32'({ack, s_zrest}), 32'(0));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    irq     = '0;
    pc_next = '0;
    z_in    = 1'b0;
    reti    = 1'b0;
    we_mask = 1'b0;
    ctrl_in = '0;

    #12;
    check_eq("rst_s_int", 32'(s_int), 32'(0));
    check_eq("rst_pc_int", 32'(pc_int), 32'(0));
    check_eq("rst_ack", 32'(ack), 32'(0));
    check_eq("rst_status", 32'(status), 32'(0));
    check_eq("rst_s_zrest", 32'(s_zrest), 32'(0));
    tick();
    reset = 1'b1;

    // Single take of source 0, Z=1 saved with return pc 012
    tick();
    write_ctrl(8'h81);
    pc_next = 10'h012;
    z_in    = 1'b1;
    sb_push(10'h3C0, 1'b0, 1'b0, 4'b0001);
    pulse_irq(0);
    settle();
    check_eq("t1_pending_status", 32'(status), 32'h81);
    check_eq("t1_no_sint_yet", 32'(s_int), 32'(0));
    tick();
    settle();
    check_eq("t1_take_sint", 32'(s_int), 32'(1));
    tick();
    settle();
    check_eq("t1_status_in_service", 32'(status), 32'hC0);

    // RETI restores pc 012 and Z=1
    tick();
    reti = 1'b1;
    sb_push(10'h012, 1'b1, 1'b1, 4'b0000);
    settle();
    check_eq("t3_reti_sint", 32'(s_int), 32'(1));
    tick();
    reti = 1'b0;
    settle();
    check_eq("t3_status_idle", 32'(status), 32'h80);

    // Source 2 in service; source 1 preempts, source 3 stays pending
    tick();
    write_ctrl(8'h8F);
    pc_next = 10'h100;
    z_in    = 1'b0;
    sb_push(10'h3C8, 1'b0, 1'b0, 4'b0100);
    pulse_irq(2);
    tick();
    tick();
    pc_next = 10'h104;
    sb_push(10'h3C4, 1'b0, 1'b0, 4'b0010);
    irq = 4'b0010;
    tick();
    irq = 4'b1000;
    tick();
    irq = 4'b0000;
    settle();
    check_eq("t2_preempt_sint", 32'(s_int), 32'(1));
    check_eq("t2_status_during_take", 32'(status), 32'hEA);
    tick();
    settle();
    check_eq("t2_status_nested", 32'(status), 32'hD8);

    // Unwind: back to id 2, then empty, then the held source 3 is taken
    tick();
    reti = 1'b1;
    sb_push(10'h104, 1'b1, 1'b0, 4'b0000);
    settle();
    tick();
    reti = 1'b0;
    settle();
    check_eq("t4_status_back_to_id2", 32'(status), 32'hE8);
    tick();
    reti = 1'b1;
    sb_push(10'h100, 1'b1, 1'b0, 4'b0000);
    settle();
    tick();
    reti    = 1'b0;
    pc_next = 10'h200;
    z_in    = 1'b1;
    sb_push(10'h3CC, 1'b0, 1'b0, 4'b1000);
    settle();
    check_eq("t4_decide_cycle_sint", 32'(s_int), 32'(0));
    check_eq("t4_status_empty_pending3", 32'(status), 32'h88);
    tick();
    settle();
    check_eq("t4_take3_sint", 32'(s_int), 32'(1));
    tick();
    settle();
    check_eq("t4_status_id3", 32'(status), 32'hF0);

    // RETI in the same cycle as a takeable source: RETI first, take deferred
    tick();
    pc_next = 10'h210;
    irq     = 4'b0001;
    tick();
    irq  = 4'b0000;
    reti = 1'b1;
    sb_push(10'h200, 1'b1, 1'b1, 4'b0000);
    sb_push(10'h3C0, 1'b0, 1'b0, 4'b0001);
    settle();
    check_eq("t4_reti_first_zrest", 32'(s_zrest), 32'(1));
    tick();
    reti = 1'b0;
    settle();
    check_eq("t4_take_deferred", 32'(s_int), 32'(0));
    tick();
    settle();
    check_eq("t4_deferred_take_ack", 32'(ack), 32'b0001);
    tick();
    settle();
    check_eq("t4_status_id0", 32'(status), 32'hC0);

    // Drain, then RETI on an empty stack must be ignored
    tick();
    reti = 1'b1;
    sb_push(10'h210, 1'b1, 1'b1, 4'b0000);
    tick();
    settle();
    check_eq("t4_empty_reti_sint", 32'(s_int), 32'(0));
    check_eq("t4_empty_reti_zrest", 32'(s_zrest), 32'(0));
    check_eq("t4_empty_reti_pc", 32'(pc_int), 32'(0));
    tick();
    reti = 1'b0;
    settle();
    check_eq("t4_status_after_empty_reti", 32'(status), 32'h80);

    // GIE off: source 2 latched but not taken until GIE is set
    tick();
    write_ctrl(8'h04);
    irq = 4'b0100;
    tick();
    irq = 4'b0000;
    settle();
    check_eq("t5_masked_pending", 32'(status), 32'h04);
    tick();
    tick();
    settle();
    check_eq("t5_no_take_masked", 32'(s_int), 32'(0));
    check_eq("t5_still_pending", 32'(status), 32'h04);
    tick();
    pc_next = 10'h300;
    z_in    = 1'b0;
    sb_push(10'h3C8, 1'b0, 1'b0, 4'b0100);
    write_ctrl(8'h84);
    settle();
    check_eq("t5_decide_cycle_sint", 32'(s_int), 32'(0));
    tick();
    settle();
    check_eq("t5_take_pc", 32'(pc_int), 32'h3C8);
    tick();
    settle();
    check_eq("t5_status_id2", 32'(status), 32'hE0);

    // Asynchronous reset in the middle of a TAKE cycle
    tick();
    write_ctrl(8'h81);
    pc_next = 10'h310;
    sb_push(10'h3C0, 1'b0, 1'b0, 4'b0001);
    pulse_irq(0);
    tick();
    settle();
    check_eq("t6_take_before_reset", 32'(s_int), 32'(1));
    #2;
    reset = 1'b0;
    #1;
    check_eq("t6_rst_s_int", 32'(s_int), 32'(0));
    check_eq("t6_rst_ack", 32'(ack), 32'(0));
    check_eq("t6_rst_status", 32'(status), 32'(0));
    tick();
    reset = 1'b1;
    settle();
    check_eq("t6_status_after_release", 32'(status), 32'(0));
    tick();
    reti = 1'b1;
    settle();
    check_eq("t6_stack_empty_reti", 32'(s_int), 32'(0));
    tick();
    reti = 1'b0;
    tick();

    check_eq("sb_drained", 32'(sb_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
